seq_detect: RTL

- Serial pattern detector that consumes the registered bit stream produced by the team's negative-edge D flip-flop stage. Its data_in is wired directly to that flop's out.
- Compares a sliding window of the last PATTERN_W sampled bits against a fixed pattern.
- Emits a one-cycle match pulse and keeps a saturating match counter for display or downstream logic.
- Supports overlapping and non-overlapping detection, selected by parameter.

---
 rtl/seq_detect_if.sv | 22 ++
 rtl/seq_detect.sv | 82 ++++++++
 2 files changed

// File: rtl/seq_detect_if.sv
// seq_detect_if: control, data and status bundle for the seq_detect pattern detector
interface seq_detect_if #(
   parameter int CNT_W = 8
);
   logic             enable;
   logic             clear;
   logic             data_in;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             overflow;
   logic [1:0]       state;

   modport master (
      output enable, clear, data_in,
      input  match, match_count, overflow, state
   );

   modport slave (
      input  enable, clear, data_in,
      output match, match_count, overflow, state
   );
endinterface

// File: rtl/seq_detect.sv
// seq_detect: falling-edge serial pattern detector with match pulse and saturating match counter
module seq_detect #(
   parameter int                   PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
   parameter bit                   OVERLAP   = 1'b1,
   parameter int                   CNT_W     = 8
) (
   input logic         clock,
   input logic         reset,
   seq_detect_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, RUN = 2'b10} state_t;

   localparam int             FW   = $clog2(PATTERN_W + 1);
   localparam logic [FW-1:0]  FULL = FW'(PATTERN_W);

   logic [PATTERN_W-1:0] hist_q, hist_d, next_hist;
   logic [FW-1:0]        fill_q, fill_d, next_fill;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 match_q, match_d;
   logic                 ovf_q, ovf_d;
   state_t               state_q, state_d;
   logic                 hit;

   // Candidate window and fill level if this edge samples data_in
   always_comb begin
      next_hist = {hist_q[PATTERN_W-2:0], bus.data_in};
      next_fill = (fill_q == FULL) ? FULL : fill_q + 1'b1;
      hit       = bus.enable && !bus.clear && (next_fill == FULL) && (next_hist == PATTERN);
   end

   // Next-state: clear beats enable; a dropped enable freezes the window but idles the FSM
   always_comb begin
      hist_d  = hist_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      match_d = 1'b0;
      state_d = state_q;
      if (bus.clear) begin
         hist_d  = '0;
         fill_d  = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         state_d = IDLE;
      end else if (!bus.enable) begin
         state_d = IDLE;
      end else begin
         match_d = hit;
         hist_d  = (hit && !OVERLAP) ? '0 : next_hist;
         fill_d  = (hit && !OVERLAP) ? '0 : next_fill;
         cnt_d   = (hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
         ovf_d   = ovf_q | (hit && (&cnt_q));
         // Leaving IDLE lands in RUN only when the retained window was already full
         state_d = (state_q == IDLE && fill_q != FULL) ? FILL : ((fill_d == FULL) ? RUN : FILL);
      end
   end

   // State register, on the falling edge to line up with the upstream flop
   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         hist_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         match_q <= 1'b0;
         state_q <= IDLE;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         match_q <= match_d;
         state_q <= state_d;
      end
   end

   assign bus.match       = match_q;
   assign bus.match_count = cnt_q;
   assign bus.overflow    = ovf_q;
   assign bus.state       = state_q;
endmodule
